// File: rtl/gpio_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_cmd_pkg
// Purpose  : Shared definitions for the 32-bit GPIO command stream. It holds
//            the command codes, the field bit positions of a command word,
//            the decoder FSM state encoding and a small command-code helper.
//            The command players and the decoder both import this package.
// Word     : {CMD[31:28], CH[27], TONE[26:24], RSV[23:20], DATA[19:0]}
// Revision : 1.0 - initial release
// ============================================================================
package gpio_cmd_pkg;

    // Command codes
    localparam logic [3:0] CMD_IDX    = 4'h1;
    localparam logic [3:0] CMD_GAIN   = 4'h2;
    localparam logic [3:0] CMD_COMMIT = 4'hF;

    // Field bit positions inside a command word
    localparam int CMD_MSB  = 31;
    localparam int CMD_LSB  = 28;
    localparam int CH_BIT   = 27;
    localparam int TONE_MSB = 26;
    localparam int TONE_LSB = 24;
    localparam int RSV_MSB  = 23;
    localparam int RSV_LSB  = 20;
    localparam int DATA_MSB = 19;
    localparam int DATA_LSB = 0;

    localparam int DATA_W    = DATA_MSB - DATA_LSB + 1;
    localparam int TONE_W    = TONE_MSB - TONE_LSB + 1;
    localparam int NUM_TONES = 1 << TONE_W;

    // Decoder FSM state encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_APPLY = 2'd2
    } dec_state_e;

    // True for the command codes the decoder acts upon
    function automatic logic cmd_known(input logic [3:0] cmd);
        return (cmd == CMD_IDX) || (cmd == CMD_GAIN) || (cmd == CMD_COMMIT);
    endfunction

endpackage : gpio_cmd_pkg
`default_nettype wire

// File: rtl/gpio_cmd_regbank.sv
`default_nettype none
// ============================================================================
// Module   : gpio_cmd_regbank
// Purpose  : Shadow and active index/gain registers for one tone-synthesis
//            channel (NUM_TONES tones). Writes land in the shadow bank; the
//            apply strobe copies the whole shadow bank into the active bank
//            in a single edge. A write at the same edge as an apply updates
//            shadow only, the active bank takes the pre-write shadow value.
// Ports    : clk, rst_n        - clock, synchronous active-low reset
//            idx_we_i          - write idx_wdata_i to shadow index[tone_i]
//            gain_we_i         - write gain_wdata_i to shadow gain[tone_i]
//            tone_i            - tone select for writes
//            apply_i           - copy shadow -> active at this edge
//            idx_flat_o        - active indices, tone t at [t*IDX_W +: IDX_W]
//            gain_flat_o       - active gains, tone t at [t*GAIN_W +: GAIN_W]
// Revision : 1.0 - initial release
// ============================================================================
module gpio_cmd_regbank
    import gpio_cmd_pkg::*;
#(
    parameter int IDX_W  = 10,
    parameter int GAIN_W = 18
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          idx_we_i,
    input  logic                          gain_we_i,
    input  logic [TONE_W-1:0]             tone_i,
    input  logic [IDX_W-1:0]              idx_wdata_i,
    input  logic [GAIN_W-1:0]             gain_wdata_i,
    input  logic                          apply_i,
    output logic [NUM_TONES*IDX_W-1:0]    idx_flat_o,
    output logic [NUM_TONES*GAIN_W-1:0]   gain_flat_o
);

    logic [IDX_W-1:0]  sh_idx_q   [NUM_TONES];
    logic [GAIN_W-1:0] sh_gain_q  [NUM_TONES];
    logic [IDX_W-1:0]  act_idx_q  [NUM_TONES];
    logic [GAIN_W-1:0] act_gain_q [NUM_TONES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TONES; t++) begin
                sh_idx_q[t]   <= '0;
                sh_gain_q[t]  <= '0;
                act_idx_q[t]  <= '0;
                act_gain_q[t] <= '0;
            end
        end else begin
            if (idx_we_i) begin
                sh_idx_q[tone_i] <= idx_wdata_i;
            end
            if (gain_we_i) begin
                sh_gain_q[tone_i] <= gain_wdata_i;
            end
            // Non-blocking semantics give the pre-write shadow value here
            if (apply_i) begin
                for (int t = 0; t < NUM_TONES; t++) begin
                    act_idx_q[t]  <= sh_idx_q[t];
                    act_gain_q[t] <= sh_gain_q[t];
                end
            end
        end
    end

    generate
        for (genvar t = 0; t < NUM_TONES; t++) begin : g_flat
            assign idx_flat_o[t*IDX_W +: IDX_W]    = act_idx_q[t];
            assign gain_flat_o[t*GAIN_W +: GAIN_W] = act_gain_q[t];
        end
    endgenerate

endmodule : gpio_cmd_regbank
`default_nettype wire

// File: rtl/gpio_cmd_decoder_shadow.sv
`default_nettype none
// ============================================================================
// Module   : gpio_cmd_decoder_shadow
// Purpose  : Receiving end of the GPIO command stream. Decodes INDEX, GAIN
//            and COMMIT words into per-channel/per-tone shadow registers and
//            atomically transfers the shadow bank to the active registers of
//            channels A and B on COMMIT, gated by commit_safe and optionally
//            forced after PEND_TIMEOUT cycles.
// Ports    : clk, rst_n                 - clock, synchronous active-low reset
//            gpio_wen, gpio_wdata       - command strobe and word
//            commit_safe                - a pending commit may apply while 1
//            idx_a/b_flat, gain_a/b_flat- active registers, per tone
//            commit_pending             - COMMIT received, not yet applied
//            commit_done                - 1-cycle pulse after each apply
//            timeout_flag               - sticky, set by a forced apply
//            err_cnt                    - saturating rejected-word count
// Config   : GPIO_DEC_CHECK_EN - when defined, words with nonzero RSV,
//            out-of-field DATA bits or unknown CMD are rejected and counted
//            in err_cnt. Otherwise fields are truncated, unknown commands
//            are dropped and err_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_cmd_decoder_shadow
    import gpio_cmd_pkg::*;
#(
    parameter int          IDX_W        = 10,
    parameter int          GAIN_W       = 18,
    parameter int unsigned PEND_TIMEOUT = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        gpio_wen,
    input  logic [31:0]                 gpio_wdata,
    input  logic                        commit_safe,
    output logic [NUM_TONES*IDX_W-1:0]  idx_a_flat,
    output logic [NUM_TONES*IDX_W-1:0]  idx_b_flat,
    output logic [NUM_TONES*GAIN_W-1:0] gain_a_flat,
    output logic [NUM_TONES*GAIN_W-1:0] gain_b_flat,
    output logic                        commit_pending,
    output logic                        commit_done,
    output logic                        timeout_flag,
    output logic [7:0]                  err_cnt
);

    // Wide enough to reach PEND_TIMEOUT before saturating
    localparam int CNT_W = $clog2(PEND_TIMEOUT + 2);

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [3:0]        w_cmd;
    logic              w_ch;
    logic [TONE_W-1:0] w_tone;
    logic [3:0]        w_rsv;
    logic [DATA_W-1:0] w_data;
    logic [31:0]       w_data32;

    assign w_cmd    = gpio_wdata[CMD_MSB:CMD_LSB];
    assign w_ch     = gpio_wdata[CH_BIT];
    assign w_tone   = gpio_wdata[TONE_MSB:TONE_LSB];
    assign w_rsv    = gpio_wdata[RSV_MSB:RSV_LSB];
    assign w_data   = gpio_wdata[DATA_MSB:DATA_LSB];
    assign w_data32 = 32'(w_data);

    // Bits that only matter when checking is compiled in
    logic w_unused_bits;
    assign w_unused_bits = ^{w_rsv, w_data32};

    // ------------------------------------------------------------------
    // Word acceptance
    // ------------------------------------------------------------------
    logic w_reject;

`ifdef GPIO_DEC_CHECK_EN
    logic [7:0] err_cnt_q;

    always_comb begin
        w_reject = 1'b0;
        if (gpio_wen) begin
            if (w_rsv != 4'd0 || !cmd_known(w_cmd)) begin
                w_reject = 1'b1;
            end else if (w_cmd == CMD_IDX) begin
                w_reject = (w_data32 >> IDX_W) != 32'd0;
            end else if (w_cmd == CMD_GAIN) begin
                w_reject = (w_data32 >> GAIN_W) != 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (w_reject && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign w_reject = 1'b0;
    assign err_cnt  = 8'd0;
`endif

    logic w_ok;
    logic w_idx_we;
    logic w_gain_we;
    logic w_commit;

    assign w_ok      = gpio_wen && !w_reject;
    assign w_idx_we  = w_ok && (w_cmd == CMD_IDX);
    assign w_gain_we = w_ok && (w_cmd == CMD_GAIN);
    assign w_commit  = w_ok && (w_cmd == CMD_COMMIT);

    // ------------------------------------------------------------------
    // Commit FSM with registered outputs
    // ------------------------------------------------------------------
    dec_state_e       state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             pend_q;
    logic             done_q;
    logic             tmo_q;
    logic             w_timeout;
    logic             w_apply;

    // Forced transition to S_APPLY at the edge where the wait counter
    // reaches PEND_TIMEOUT; PEND_TIMEOUT == 0 never times out.
    assign w_timeout = (PEND_TIMEOUT != 0) &&
                       ((32'(wait_cnt_q) + 32'd1) >= PEND_TIMEOUT);

    assign w_apply = (state_q == S_APPLY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (w_commit) begin
                        state_q    <= S_PEND;
                        wait_cnt_q <= '0;
                        pend_q     <= 1'b1;
                    end
                end
                S_PEND: begin
                    // Further COMMITs here merge into this episode
                    if (wait_cnt_q != '1) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                    if (commit_safe) begin
                        state_q <= S_APPLY;
                    end else if (w_timeout) begin
                        state_q <= S_APPLY;
                        tmo_q   <= 1'b1;
                    end
                end
                S_APPLY: begin
                    // The regbanks copy shadow -> active at this edge
                    done_q     <= 1'b1;
                    wait_cnt_q <= '0;
                    if (w_commit) begin
                        // New episode starts right away; pending stays high
                        state_q <= S_PEND;
                        pend_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        pend_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign commit_pending = pend_q;
    assign commit_done    = done_q;
    assign timeout_flag   = tmo_q;

    // ------------------------------------------------------------------
    // Per-channel register banks
    // ------------------------------------------------------------------
    gpio_cmd_regbank #(
        .IDX_W  (IDX_W),
        .GAIN_W (GAIN_W)
    ) u_bank_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .idx_we_i     (w_idx_we && !w_ch),
        .gain_we_i    (w_gain_we && !w_ch),
        .tone_i       (w_tone),
        .idx_wdata_i  (w_data32[IDX_W-1:0]),
        .gain_wdata_i (w_data32[GAIN_W-1:0]),
        .apply_i      (w_apply),
        .idx_flat_o   (idx_a_flat),
        .gain_flat_o  (gain_a_flat)
    );

    gpio_cmd_regbank #(
        .IDX_W  (IDX_W),
        .GAIN_W (GAIN_W)
    ) u_bank_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .idx_we_i     (w_idx_we && w_ch),
        .gain_we_i    (w_gain_we && w_ch),
        .tone_i       (w_tone),
        .idx_wdata_i  (w_data32[IDX_W-1:0]),
        .gain_wdata_i (w_data32[GAIN_W-1:0]),
        .apply_i      (w_apply),
        .idx_flat_o   (idx_b_flat),
        .gain_flat_o  (gain_b_flat)
    );

endmodule : gpio_cmd_decoder_shadow
`default_nettype wire

// File: tb/tb_gpio_cmd_decoder_shadow.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_cmd_decoder_shadow
// Purpose  : Self-checking bench for gpio_cmd_decoder_shadow. dut0 uses
//            PEND_TIMEOUT=0, dut1 uses PEND_TIMEOUT=20. A shadow/active
//            model predicts each apply; snapshots are queued when a commit
//            is set up and compared when commit_done is seen.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gpio_cmd_decoder_shadow;

    localparam int IW = 10;
    localparam int GW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wen, safe, wen1, safe1;
    logic [31:0] wdata, wdata1;

    logic [8*IW-1:0] idx_a, idx_b, idx_a1, idx_b1;
    logic [8*GW-1:0] gain_a, gain_b, gain_a1, gain_b1;
    logic            pend, done, tmo, pend1, done1, tmo1;
    logic [7:0]      err, err1;

    gpio_cmd_decoder_shadow #(.IDX_W(IW), .GAIN_W(GW), .PEND_TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .gpio_wen(wen), .gpio_wdata(wdata),
        .commit_safe(safe), .idx_a_flat(idx_a), .idx_b_flat(idx_b),
        .gain_a_flat(gain_a), .gain_b_flat(gain_b), .commit_pending(pend),
        .commit_done(done), .timeout_flag(tmo), .err_cnt(err));

    gpio_cmd_decoder_shadow #(.IDX_W(IW), .GAIN_W(GW), .PEND_TIMEOUT(20)) dut1 (
        .clk(clk), .rst_n(rst_n), .gpio_wen(wen1), .gpio_wdata(wdata1),
        .commit_safe(safe1), .idx_a_flat(idx_a1), .idx_b_flat(idx_b1),
        .gain_a_flat(gain_a1), .gain_b_flat(gain_b1), .commit_pending(pend1),
        .commit_done(done1), .timeout_flag(tmo1), .err_cnt(err1));

    typedef struct {
        logic        ch;
        logic [2:0]  tone;
        logic [19:0] idx_d;
        logic [19:0] gain_d;
        logic [IW-1:0] exp_idx;
        logic [GW-1:0] exp_gain;
    } vec_t;

    typedef struct {
        logic [8*IW-1:0] ia, ib;
        logic [8*GW-1:0] ga, gb;
    } snap_t;

    vec_t  vt[16];
    snap_t sb[$];

    logic [8*IW-1:0] m_idx[2];
    logic [8*GW-1:0] m_gain[2];
    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] cmd, input logic ch,
                                       input logic [2:0] tone, input logic [19:0] d);
        return {cmd, ch, tone, 4'h0, d};
    endfunction

    // Behavioural model of one accepted/rejected word
    task automatic model_write(input logic [31:0] w);
        logic [3:0]  cmd;
        logic [19:0] d;
        int          t;
        bit          rej;
        cmd = w[31:28];
        d   = w[19:0];
        t   = int'(w[26:24]);
        rej = 1'b0;
`ifdef GPIO_DEC_CHECK_EN
        if (w[23:20] != 4'd0) rej = 1'b1;
        else if (cmd == 4'h1) rej = (32'(d) >> IW) != 0;
        else if (cmd == 4'h2) rej = (32'(d) >> GW) != 0;
        else if (cmd != 4'hF) rej = 1'b1;
        if (rej && exp_err != 255) exp_err++;
`endif
        if (!rej && cmd == 4'h1) m_idx[w[27]][t*IW +: IW] = d[IW-1:0];
        if (!rej && cmd == 4'h2) m_gain[w[27]][t*GW +: GW] = d[GW-1:0];
    endtask

    task automatic wr(input logic [31:0] w);
        wen   = 1'b1;
        wdata = w;
        tick();
        wen   = 1'b0;
        model_write(w);
    endtask

    task automatic wr1(input logic [31:0] w);
        wen1   = 1'b1;
        wdata1 = w;
        tick();
        wen1   = 1'b0;
    endtask

    task automatic push_exp();
        snap_t s;
        s.ia = m_idx[0];  s.ib = m_idx[1];
        s.ga = m_gain[0]; s.gb = m_gain[1];
        sb.push_back(s);
    endtask

    task automatic pop_cmp(input string nm);
        snap_t s;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 320'(0), 320'(1));
            return;
        end
        s = sb.pop_front();
        chk({nm, "_idx_a"},  320'(idx_a),  320'(s.ia));
        chk({nm, "_idx_b"},  320'(idx_b),  320'(s.ib));
        chk({nm, "_gain_a"}, 320'(gain_a), 320'(s.ga));
        chk({nm, "_gain_b"}, 320'(gain_b), 320'(s.gb));
    endtask

    // Waits (bounded) for commit_done, checks latency and the queued snapshot
    task automatic wait_done(input int exp_lat, input string nm);
        int lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({nm, "_lat"}, 320'(lat), 320'(exp_lat));
        pop_cmp(nm);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_idx[0] = '0; m_idx[1] = '0; m_gain[0] = '0; m_gain[1] = '0;
        sb.delete();
        exp_err = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        int lat;
        logic tmo19;

        vt[0]  = '{1'b0, 3'd0, 20'h00011, 20'h00123, 10'h011, 18'h00123};
        vt[1]  = '{1'b0, 3'd1, 20'h003FF, 20'h3FFFF, 10'h3FF, 18'h3FFFF};
        vt[2]  = '{1'b0, 3'd2, 20'h00001, 20'h00001, 10'h001, 18'h00001};
        vt[3]  = '{1'b0, 3'd3, 20'h00155, 20'h15555, 10'h155, 18'h15555};
        vt[4]  = '{1'b0, 3'd4, 20'h002AA, 20'h2AAAA, 10'h2AA, 18'h2AAAA};
        vt[5]  = '{1'b0, 3'd5, 20'h00100, 20'h20000, 10'h100, 18'h20000};
        vt[6]  = '{1'b0, 3'd6, 20'h000F0, 20'h0F0F0, 10'h0F0, 18'h0F0F0};
        vt[7]  = '{1'b0, 3'd7, 20'h003C3, 20'h12345, 10'h3C3, 18'h12345};
        vt[8]  = '{1'b1, 3'd0, 20'h00200, 20'h00400, 10'h200, 18'h00400};
        vt[9]  = '{1'b1, 3'd1, 20'h0007E, 20'h1FFFF, 10'h07E, 18'h1FFFF};
        vt[10] = '{1'b1, 3'd2, 20'h00381, 20'h0ABCD, 10'h381, 18'h0ABCD};
        vt[11] = '{1'b1, 3'd3, 20'h000C0, 20'h30303, 10'h0C0, 18'h30303};
        vt[12] = '{1'b1, 3'd4, 20'h00111, 20'h11111, 10'h111, 18'h11111};
        vt[13] = '{1'b1, 3'd5, 20'h003A5, 20'h2BEEF, 10'h3A5, 18'h2BEEF};
        vt[14] = '{1'b1, 3'd6, 20'h00222, 20'h22222, 10'h222, 18'h22222};
        vt[15] = '{1'b1, 3'd7, 20'h00333, 20'h33333, 10'h333, 18'h33333};

        wen = 1'b0; wdata = '0; safe = 1'b0;
        wen1 = 1'b0; wdata1 = '0; safe1 = 1'b0;
        rst_n = 1'b0;

        // ---- Reset state ----
        do_reset();
        chk("rst_idx",  320'({idx_a, idx_b}), 320'(0));
        chk("rst_gain", 320'({gain_a, gain_b}), 320'(0));
        chk("rst_flags", 320'({pend, done, tmo, err}), 320'(0));
        chk("rst_dut1", 320'({pend1, done1, tmo1}), 320'(0));

        // ---- INDEX B/5 = 0x3A5, COMMIT with safe=1, latency 2 ----
        safe = 1'b1;
        wr(mk(4'h1, 1'b1, 3'd5, 20'h003A5));
        tick();
        chk("t1_pre_idx", 320'(idx_b[5*IW +: IW]), 320'(0));
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        chk("t1_pending", 320'(pend), 320'(1));
        push_exp();
        wait_done(2, "t1");
        chk("t1_idx_b5", 320'(idx_b[5*IW +: IW]), 320'(10'h3A5));
        chk("t1_pend_drop", 320'(pend), 320'(0));
        tick();
        chk("t1_done_pulse", 320'(done), 320'(0));

        // ---- Full sequence, held pending for 50 cycles ----
        do_reset();
        safe = 1'b0;
        for (int i = 0; i < 16; i++) wr(mk(4'h1, vt[i].ch, vt[i].tone, vt[i].idx_d));
        for (int i = 0; i < 16; i++) wr(mk(4'h2, vt[i].ch, vt[i].tone, vt[i].gain_d));
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        for (int c = 0; c < 50; c++) begin
            chk("hold_pend", 320'(pend), 320'(1));
            chk("hold_done", 320'(done), 320'(0));
            chk("hold_idx",  320'({idx_a, idx_b}), 320'(0));
            chk("hold_gain", 320'({gain_a, gain_b}), 320'(0));
            tick();
        end
        chk("hold_tmo", 320'(tmo), 320'(0));
        safe = 1'b1;
        push_exp();
        tick();
        chk("t2_pre_apply", 320'({idx_a, gain_a, gain_b}), 320'(0));
        wait_done(1, "t2");
        for (int i = 0; i < 16; i++) begin
            int t;
            t = int'(vt[i].tone);
            chk($sformatf("row%0d_idx", i),
                320'(vt[i].ch ? idx_b[t*IW +: IW] : idx_a[t*IW +: IW]), 320'(vt[i].exp_idx));
            chk($sformatf("row%0d_gain", i),
                320'(vt[i].ch ? gain_b[t*GW +: GW] : gain_a[t*GW +: GW]), 320'(vt[i].exp_gain));
        end

        // ---- Write at the apply edge lands in shadow only ----
        wr(mk(4'h2, 1'b0, 3'd7, 20'h00AAA));
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        push_exp();
        tick();
        wr(mk(4'h2, 1'b0, 3'd7, 20'h1FFFF));
        chk("t4_done_at_apply", 320'(done), 320'(1));
        pop_cmp("t4a");
        chk("t4_old_gain", 320'(gain_a[7*GW +: GW]), 320'(18'h00AAA));
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        push_exp();
        wait_done(2, "t4b");
        chk("t4_new_gain", 320'(gain_a[7*GW +: GW]), 320'(18'h1FFFF));

        // ---- Two COMMITs one cycle apart, safe=0 -> single done ----
        safe = 1'b0;
        wr(mk(4'h1, 1'b0, 3'd2, 20'h00077));
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        tick();
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("t5_no_early_done", 320'(ndone), 320'(0));
        safe = 1'b1;
        push_exp();
        wait_done(2, "t5");
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("t5_single_done", 320'(ndone), 320'(0));
        chk("t5_pend_clear", 320'(pend), 320'(0));

        // ---- COMMIT during S_APPLY re-enters pending ----
        wr(mk(4'h1, 1'b1, 3'd3, 20'h00246));
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        push_exp();
        tick();
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        chk("t6_done1", 320'(done), 320'(1));
        chk("t6_pend_kept", 320'(pend), 320'(1));
        pop_cmp("t6a");
        push_exp();
        wait_done(2, "t6b");
        chk("t6_pend_drop", 320'(pend), 320'(0));

        // ---- Reset mid-pending ----
        safe = 1'b0;
        wr(mk(4'h1, 1'b0, 3'd1, 20'h002AA));
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        tick(); tick(); tick();
        chk("t7_pend_before", 320'(pend), 320'(1));
        rst_n = 1'b0;
        tick();
        chk("t7_rst_idx",  320'({idx_a, idx_b}), 320'(0));
        chk("t7_rst_gain", 320'({gain_a, gain_b}), 320'(0));
        chk("t7_rst_flags", 320'({pend, done, tmo}), 320'(0));
        do_reset();
        safe = 1'b1;
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("t7_discarded", 320'({31'(ndone), pend}), 320'(0));

        // ---- Checked words ----
        wr(32'h1010_0001);
        wr(32'h7000_0000);
        wr(mk(4'hF, 1'b0, 3'd0, 20'h0));
        push_exp();
        wait_done(2, "t8");
`ifdef GPIO_DEC_CHECK_EN
        chk("t8_idx_a0", 320'(idx_a[IW-1:0]), 320'(0));
        chk("t8_err", 320'(err), 320'(2));
`else
        chk("t8_idx_a0", 320'(idx_a[IW-1:0]), 320'(1));
        chk("t8_err", 320'(err), 320'(0));
`endif
        chk("t8_err_model", 320'(err), 320'(exp_err));

        // ---- Timeout on dut1 (PEND_TIMEOUT=20) ----
        safe1 = 1'b0;
        wr1(mk(4'h1, 1'b0, 3'd0, 20'h00155));
        wr1(mk(4'hF, 1'b0, 3'd0, 20'h0));
        lat = 0;
        tmo19 = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 19) tmo19 = tmo1;
            if (done1) begin
                lat = i;
                break;
            end
        end
        chk("t9_lat", 320'(lat), 320'(21));
        chk("t9_tmo_before", 320'(tmo19), 320'(0));
        chk("t9_tmo_set", 320'(tmo1), 320'(1));
        chk("t9_idx", 320'(idx_a1[IW-1:0]), 320'(10'h155));
        safe1 = 1'b1;
        wr1(mk(4'h1, 1'b0, 3'd0, 20'h00099));
        wr1(mk(4'hF, 1'b0, 3'd0, 20'h0));
        tick(); tick(); tick();
        chk("t9_idx2", 320'(idx_a1[IW-1:0]), 320'(10'h099));
        chk("t9_tmo_sticky", 320'({tmo1, pend1}), 320'(2'b10));
        chk("t9_dut0_tmo", 320'(tmo), 320'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gpio_cmd_decoder_shadow
`default_nettype wire
